tb_uart: RTL and testbench



---
 rtl/tb_uart_pkg.sv | 14 +
 rtl/tb_uart_rx_decoder.sv | 111 +++++++++++
 rtl/tb_uart.sv | 125 ++++++++++++
 tb/tb_tb_uart.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tb_uart_pkg.sv
// Shared definitions for the bench-side UART model: frame state encoding and frame geometry.
package tb_uart_pkg;

  // One encoding serves both the TX and RX state machines.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam int unsigned DataBits = 8;

endpackage

// File: rtl/tb_uart_rx_decoder.sv
// Receive side of the bench UART: synchronises the serial line and decodes 8N1 frames by
// mid-bit sampling. Reports each decoded byte or framing error as a one-cycle pulse.
module tb_uart_rx_decoder
  import tb_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 347
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_DIV / 2 - 1);

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            sync1_q, sync2_q, prev_q;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            fall, half_hit, bit_hit;

  assign fall     = prev_q & ~sync2_q;
  assign half_hit = (cnt_q == HalfLast);
  assign bit_hit  = (cnt_q == BaudLast);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: START re-checks the line half a bit in to reject glitches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fall) state_d = StStart;
      StStart: if (half_hit) state_d = sync2_q ? StIdle : StData;
      StData:  if (bit_hit && bit_cnt_q == 3'd7) state_d = StStop;
      StStop:  if (bit_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: baud counter, bit index, shift register and report pulses.
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
      end
      StStart: if (half_hit) cnt_d = '0;
      StData: if (bit_hit) begin
        cnt_d     = '0;
        bit_cnt_d = bit_cnt_q + 1'b1;
        shift_d   = {sync2_q, shift_q[7:1]};
      end
      StStop: if (bit_hit) begin
        cnt_d   = '0;
        valid_d = sync2_q;
        err_d   = ~sync2_q;
      end
      default: cnt_d = '0;
    endcase
  end

  // Synchroniser, edge-detect history and datapath registers; line idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Report outputs come straight from registers.
  always_comb begin
    valid_o     = valid_q;
    data_o      = shift_q;
    frame_err_o = err_q;
  end

endmodule

// File: rtl/tb_uart.sv
// Bench-side UART model: 8N1 transmitter with start/busy/clear handshake, plus a receive
// decoder for the chip's serial output.
module tb_uart
  import tb_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 347
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_clear_req
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);

  uart_state_e     tx_state_q, tx_state_d;
  logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            start_q;
  logic            clear_q, clear_d;
  logic            launch, bit_end;

  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            rx_frame_err;

  // Only a 0->1 transition while idle launches; a held-high request never re-launches.
  assign launch  = tx_start & ~start_q & (tx_state_q == StIdle);
  assign bit_end = (tx_state_q != StIdle) && (baud_cnt_q == BaudLast);

  // TX state register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx_state_q <= StIdle;
    end else begin
      tx_state_q <= tx_state_d;
    end
  end

  // TX next-state: each non-idle state holds for one bit period per bit.
  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      StIdle:  if (launch) tx_state_d = StStart;
      StStart: if (bit_end) tx_state_d = StData;
      StData:  if (bit_end && bit_cnt_q == 3'd7) tx_state_d = StStop;
      StStop:  if (bit_end) tx_state_d = StIdle;
      default: tx_state_d = StIdle;
    endcase
  end

  // TX outputs decoded from state so reset returns the line high immediately.
  always_comb begin
    ser_tx       = 1'b1;
    tx_busy      = 1'b0;
    tx_clear_req = clear_q;
    unique case (tx_state_q)
      StIdle:  ser_tx = 1'b1;
      StStart: begin
        ser_tx  = 1'b0;
        tx_busy = 1'b1;
      end
      StData: begin
        ser_tx  = shift_q[0];
        tx_busy = 1'b1;
      end
      StStop:  tx_busy = 1'b1;
      default: ser_tx = 1'b1;
    endcase
  end

  // TX datapath next values; the byte is captured at launch so later tx_data changes are ignored.
  always_comb begin
    baud_cnt_d = (tx_state_q == StIdle || bit_end) ? '0 : baud_cnt_q + 1'b1;
    bit_cnt_d  = (tx_state_q != StData) ? 3'd0 :
                 bit_end                ? bit_cnt_q + 1'b1 : bit_cnt_q;
    shift_d    = shift_q;
    if (launch) begin
      shift_d = tx_data;
    end else if (tx_state_q == StData && bit_end) begin
      shift_d = shift_q >> 1;
    end
    clear_d = clear_q;
    if (tx_state_q == StStop && bit_end) begin
      clear_d = 1'b1;
    end else if (launch || !tx_start) begin
      clear_d = 1'b0;
    end
  end

  // TX datapath registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      start_q    <= 1'b0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      clear_q    <= 1'b0;
    end else begin
      start_q    <= tx_start;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      clear_q    <= clear_d;
    end
  end

  tb_uart_rx_decoder #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk_i       (clock),
    .rst_ni      (resetb),
    .rx_i        (ser_rx),
    .valid_o     (rx_valid),
    .data_o      (rx_data),
    .frame_err_o (rx_frame_err)
  );

endmodule

// File: tb/tb_tb_uart.sv
// Self-checking bench for tb_uart with BAUD_DIV=8: TX waveform, handshake, loopback decode,
// RX glitch/framing handling and mid-frame reset.
module tb_tb_uart;

  localparam int unsigned B = 8;

  logic       clock = 1'b0;
  logic       resetb = 1'b1;
  logic       ser_rx;
  logic       ser_tx;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy;
  logic       tx_clear_req;
  logic       loop_en = 1'b0;
  logic       ser_rx_drv = 1'b1;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  logic [7:0] rx_got[$];
  logic [7:0] exp_rx[$];

  assign ser_rx = loop_en ? ser_tx : ser_rx_drv;

  always #5 clock = ~clock;

  tb_uart #(
    .BAUD_DIV (B)
  ) dut (
    .clock        (clock),
    .resetb       (resetb),
    .ser_rx       (ser_rx),
    .ser_tx       (ser_tx),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req)
  );

  // Log what the receive decoder reports and collect it for comparison.
  always @(negedge clock) begin
    if (dut.u_rx.valid_o === 1'b1) begin
      $display("tbuart: rx 0x%02h", dut.u_rx.data_o);
      rx_got.push_back(dut.u_rx.data_o);
    end
    if (dut.u_rx.frame_err_o === 1'b1) begin
      $display("tbuart: framing error");
      err_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for cycle j of a frame carrying d: start 0, data LSB first, stop 1.
  function automatic logic frame_bit(input logic [7:0] d, input int j);
    int b;
    b = j / B;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit hold);
    logic [79:0] obs_w, exp_w, busy_w;
    int lat;
    bit found;
    bit relaunch;
    @(posedge clock);
    #1;
    tx_data  = d;
    tx_start = 1'b1;
    found = 1'b0;
    lat = 0;
    for (int i = 1; i <= 4 && !found; i++) begin
      @(negedge clock);
      if (ser_tx === 1'b0) begin
        found = 1'b1;
        lat = i;
      end
    end
    check("launch_latency", 80'(lat), 80'd2);
    if (!found) begin
      tx_start = 1'b0;
      return;
    end
    if (loop_en) exp_rx.push_back(d);
    tx_data = ~d;
    for (int j = 0; j < 80; j++) begin
      if (j > 0) @(negedge clock);
      obs_w[j]  = ser_tx;
      busy_w[j] = tx_busy;
      exp_w[j]  = frame_bit(d, j);
    end
    check("frame_bits", obs_w, exp_w);
    check("busy_window", busy_w, {80{1'b1}});
    @(negedge clock);
    check("busy_end", 80'(tx_busy), 80'd0);
    check("clear_set", 80'(tx_clear_req), 80'd1);
    check("line_idle", 80'(ser_tx), 80'd1);
    if (hold) begin
      relaunch = 1'b0;
      repeat (30) begin
        @(negedge clock);
        if (ser_tx !== 1'b1 || tx_busy !== 1'b0) relaunch = 1'b1;
      end
      check("no_relaunch", 80'(relaunch), 80'd0);
      check("clear_held", 80'(tx_clear_req), 80'd1);
    end
    @(posedge clock);
    #1;
    tx_start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("clear_drop", 80'(tx_clear_req), 80'd0);
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    @(posedge clock);
    #1;
    for (int i = 0; i < 10; i++) begin
      ser_rx_drv = bits[i];
      repeat (B) @(posedge clock);
      #1;
    end
    ser_rx_drv = 1'b1;
    repeat (20) @(posedge clock);
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, 80'(rx_got.size()), 80'(exp_rx.size()));
    for (int i = 0; i < rx_got.size() && i < exp_rx.size(); i++) begin
      check({tag, "_byte"}, 80'(rx_got[i]), 80'(exp_rx[i]));
    end
  endtask

  initial begin
    logic [7:0] d;
    bit found;
    int rx_before;

    // Reset values.
    #2 resetb = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ser_tx", 80'(ser_tx), 80'd1);
    check("rst_busy", 80'(tx_busy), 80'd0);
    check("rst_clear", 80'(tx_clear_req), 80'd0);
    resetb = 1'b1;
    repeat (3) @(posedge clock);

    // Basic frame and held-start frame.
    send_frame(8'h0F, 1'b0);
    send_frame(8'h3D, 1'b1);

    // Loopback, fixed and random bytes.
    loop_en = 1'b1;
    send_frame(8'h0F, 1'b0);
    send_frame(8'h3D, 1'b0);
    send_frame(8'h0F, 1'b0);
    send_frame(8'h3D, 1'b0);
    repeat (3) send_frame(8'($urandom_range(0, 255)), 1'b0);
    repeat (10) @(posedge clock);
    compare_rx("loopback");
    loop_en = 1'b0;

    // Short low glitch must be rejected silently.
    rx_before = rx_got.size();
    @(posedge clock);
    #1 ser_rx_drv = 1'b0;
    repeat (2) @(posedge clock);
    #1 ser_rx_drv = 1'b1;
    repeat (100) @(posedge clock);
    check("glitch_no_byte", 80'(rx_got.size()), 80'(rx_before));
    check("glitch_no_err", 80'(err_cnt), 80'd0);

    // Stop bit 0 gives a framing error and no byte.
    drive_rx(8'($urandom_range(0, 255)), 1'b0);
    check("frame_err", 80'(err_cnt), 80'd1);
    check("frame_err_no_byte", 80'(rx_got.size()), 80'(rx_before));

    // A well-formed externally driven frame decodes.
    d = 8'($urandom_range(0, 255));
    exp_rx.push_back(d);
    drive_rx(d, 1'b1);
    compare_rx("rx_drive");

    // Reset during data bit 3, then a clean frame.
    d = 8'($urandom_range(0, 255));
    @(posedge clock);
    #1;
    tx_data  = d;
    tx_start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clock);
      if (ser_tx === 1'b0) found = 1'b1;
    end
    check("mid_launch", 80'(found), 80'd1);
    repeat (35) @(negedge clock);
    check("mid_bit3", 80'(ser_tx), 80'(d[3]));
    #1 resetb = 1'b0;
    #1;
    check("mid_rst_ser_tx", 80'(ser_tx), 80'd1);
    check("mid_rst_busy", 80'(tx_busy), 80'd0);
    check("mid_rst_clear", 80'(tx_clear_req), 80'd0);
    tx_start = 1'b0;
    @(posedge clock);
    #1 resetb = 1'b1;
    repeat (3) @(posedge clock);
    send_frame(8'($urandom_range(0, 255)), 1'b0);
    check("no_stray_rx", 80'(rx_got.size()), 80'(exp_rx.size()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
